// File: rtl/my_float_to_fixed_pkg.sv
// Shared single-precision float definitions for the float units:
// field widths, bias, saturation constants and the unpacked-operand record.
package my_float_to_fixed_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int SHIFT_W = 10;
  localparam int FRAC_W  = 5;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  // Largest representable magnitude for each sign, one bit wider than the result
  localparam logic [32:0] MAG_LIM_POS = 33'h0_7FFF_FFFF;
  localparam logic [32:0] MAG_LIM_NEG = 33'h0_8000_0000;

  // Left shifts beyond this always exceed 2^31 because the hidden bit is set
  localparam int MAX_LSHIFT = 8;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } float_class_e;

  // shift is two's complement: bit SHIFT_W-1 set means a right shift
  typedef struct packed {
    logic               sign;
    float_class_e       cls;
    logic [MAN_W:0]     mant;
    logic [SHIFT_W-1:0] shift;
  } unpacked_t;

  function automatic logic [31:0] sat_value(input logic sign);
    return sign ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/my_float_to_fixed_if.sv
// Accelerator-side bundle of the float-to-fixed unit: run control, config,
// operand in and fixed-point result / saturation counter out.
interface my_float_to_fixed_if #(
  parameter int DATA_W = 32
);
  logic              run;
  logic              running;
  logic [31:0]       delay0;
  logic [4:0]        frac_bits;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] out0;
  logic [31:0]       sat_count;

  modport master (
    output run, running, delay0, frac_bits, in0,
    input  out0, sat_count
  );

  modport slave (
    input  run, running, delay0, frac_bits, in0,
    output out0, sat_count
  );
endinterface

// File: rtl/float_unpack.sv
// Combinational unpack of an IEEE-754 single: sign, class, mantissa with
// hidden bit, and the signed shift that aligns it to frac_bits fraction bits.
module float_unpack
  import my_float_to_fixed_pkg::*;
(
  input  logic [31:0]       f_i,
  input  logic [FRAC_W-1:0] frac_bits_i,
  output unpacked_t         u_o
);

  logic [EXP_W-1:0] exp_w;
  logic [MAN_W-1:0] man_w;

  assign exp_w = f_i[30:23];
  assign man_w = f_i[22:0];

  always_comb begin
    u_o.sign = f_i[31];
    u_o.mant = {1'b1, man_w};
    // value = mant * 2^(exp - BIAS - MAN_W); scaling by 2^frac_bits adds frac_bits
    u_o.shift = {{(SHIFT_W-EXP_W){1'b0}}, exp_w}
              - SHIFT_W'(BIAS + MAN_W)
              + {{(SHIFT_W-FRAC_W){1'b0}}, frac_bits_i};
    if (exp_w == '0) begin
      u_o.cls = CLS_ZERO;
    end else if (exp_w == '1) begin
      u_o.cls = (man_w == '0) ? CLS_INF : CLS_NAN;
    end else begin
      u_o.cls = CLS_NORM;
    end
  end

endmodule

// File: rtl/my_float_to_fixed.sv
// Three-stage float-to-fixed pipeline (unpack, align/overflow, negate/saturate)
// advancing only while running; counts saturated valid results since the last run.
module my_float_to_fixed
  import my_float_to_fixed_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             rst,
  my_float_to_fixed_if.slave bus
);

  logic [31:0]       delay_q, delay_d;
  logic              armed_q, armed_d;

  unpacked_t         unp;
  unpacked_t         s1_q;
  logic              s1_valid_q, s1_valid_d;

  logic              s2_valid_q;
  logic              s2_sign_q;
  logic              s2_sat_q;
  logic [31:0]       s2_mag_q;

  logic [SHIFT_W-1:0] neg_shift;
  logic [32:0]        left_wide;
  logic [32:0]        limit;
  logic               ovf;
  logic [31:0]        mag_d;
  logic               sat_d;

  logic [DATA_W-1:0] out0_q, out0_d;
  logic [31:0]       sat_count_q, sat_count_d;

  float_unpack u_unpack (
    .f_i         (bus.in0),
    .frac_bits_i (bus.frac_bits),
    .u_o         (unp)
  );

  // Run control: armed stays low after reset until the first run pulse
  always_comb begin
    delay_d = delay_q;
    armed_d = armed_q;
    if (bus.run) begin
      delay_d = bus.delay0;
      armed_d = 1'b1;
    end else if (delay_q != '0) begin
      delay_d = delay_q - 32'd1;
    end
    s1_valid_d = armed_q && !bus.run && (delay_q == '0);
  end

  // Stage 2: align magnitude and detect overflow against the sign-dependent limit
  always_comb begin
    neg_shift = -s1_q.shift;
    left_wide = '0;
    limit     = s1_q.sign ? MAG_LIM_NEG : MAG_LIM_POS;
    ovf       = 1'b0;
    mag_d     = '0;
    sat_d     = 1'b0;
    if (!s1_q.shift[SHIFT_W-1]) begin
      if (s1_q.shift > SHIFT_W'(MAX_LSHIFT)) begin
        ovf = 1'b1;
      end else begin
        left_wide = 33'(s1_q.mant) << s1_q.shift[3:0];
        ovf       = left_wide > limit;
        mag_d     = left_wide[31:0];
      end
    end else if (neg_shift < SHIFT_W'(MAN_W + 1)) begin
      mag_d = 32'(s1_q.mant >> neg_shift[4:0]);
    end
    case (s1_q.cls)
      CLS_NORM: sat_d = ovf;
      CLS_INF: begin
        sat_d = 1'b1;
        mag_d = '0;
      end
      default: mag_d = '0;
    endcase
  end

  // Stage 3 result and the saturation counter; run clears ahead of any increment
  always_comb begin
    if (s2_sat_q) begin
      out0_d = sat_value(s2_sign_q);
    end else begin
      out0_d = s2_sign_q ? -s2_mag_q : s2_mag_q;
    end
    sat_count_d = sat_count_q;
    if (bus.run) begin
      sat_count_d = '0;
    end else if (bus.running && s2_valid_q && s2_sat_q && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_q     <= '0;
      armed_q     <= 1'b0;
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_sat_q    <= 1'b0;
      s2_mag_q    <= '0;
      out0_q      <= '0;
      sat_count_q <= '0;
    end else begin
      delay_q     <= delay_d;
      armed_q     <= armed_d;
      sat_count_q <= sat_count_d;
      if (bus.running) begin
        s1_q       <= unp;
        s1_valid_q <= s1_valid_d;
        s2_valid_q <= s1_valid_q;
        s2_sign_q  <= s1_q.sign;
        s2_sat_q   <= sat_d;
        s2_mag_q   <= mag_d;
        out0_q     <= out0_d;
      end
    end
  end

  assign bus.out0      = out0_q;
  assign bus.sat_count = sat_count_q;

endmodule

// File: tb/tb_my_float_to_fixed.sv
// Scoreboard bench for my_float_to_fixed: stimulus pushes reference results,
// a monitor pops them after three advancing edges and compares.
module tb_my_float_to_fixed;

  typedef struct {
    logic [31:0] val;
    bit          sat;
    bit          valid;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  my_float_to_fixed_if #(.DATA_W(32)) bus();

  my_float_to_fixed #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  entry_t      sb[$];
  logic [31:0] m_cnt   = '0;
  bit          m_armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: exact value mant*2^(exp-150+fb) with plain integer arithmetic
  function automatic entry_t convert(input logic [31:0] f, input int fb);
    entry_t r;
    int     e;
    int     sh;
    longint m;
    longint mag;
    longint lim;
    bit     s;
    r.val   = '0;
    r.sat   = 1'b0;
    r.valid = 1'b0;
    e = int'(f[30:23]);
    m = longint'({1'b1, f[22:0]});
    s = f[31];
    if (e == 0) return r;
    if (e == 255) begin
      if (f[22:0] != 0) return r;
      r.sat = 1'b1;
      r.val = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return r;
    end
    sh = e - 150 + fb;
    if (sh > 31)        mag = 64'h1_0000_0000;
    else if (sh >= 0)   mag = m << sh;
    else if (-sh >= 24) mag = 0;
    else                mag = m >> (-sh);
    lim = s ? 64'h8000_0000 : 64'h7FFF_FFFF;
    if (mag > lim) begin
      r.sat = 1'b1;
      r.val = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      r.val = s ? 32'(-mag) : 32'(mag);
    end
    return r;
  endfunction

  task automatic step(input bit r, input bit rn, input logic [31:0] f,
                      input logic [4:0] fb, input logic [31:0] d0);
    entry_t e;
    @(negedge clk);
    bus.run       = r;
    bus.running   = rn;
    bus.in0       = f;
    bus.frac_bits = fb;
    bus.delay0    = d0;
    if (rn) begin
      e       = convert(f, int'(fb));
      e.valid = m_armed && !r && (m_cnt == 0);
      sb.push_back(e);
    end
    if (r) begin
      m_cnt   = d0;
      m_armed = 1'b1;
    end else if (m_cnt != 0) begin
      m_cnt = m_cnt - 1;
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 32'h3FC0_0000, 5'd8, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_out0", bus.out0, 32'h0);
    chk("async_rst_sat", bus.sat_count, 32'h0);
    sb.delete();
    m_cnt       = '0;
    m_armed     = 1'b0;
    bus.run     = 1'b0;
    bus.running = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f = $urandom;
    case ($urandom_range(0, 7))
      0, 1, 2, 3: f[30:23] = 8'($urandom_range(100, 160));
      4: f[30:23] = 8'd0;
      5: begin
        f[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) f[22:0] = '0;
      end
      6: begin
        f[30:23] = 8'($urandom_range(150, 159));
        f[22:0]  = '0;
      end
      default: ;
    endcase
    return f;
  endfunction

  // Monitor: one pop per advancing edge once three advances have occurred
  initial begin : monitor
    bit          adv;
    bit          r;
    bit          in_rst;
    int          n_adv;
    bit          have;
    logic [31:0] last_val;
    logic [31:0] sat_m;
    entry_t      e;
    n_adv    = 0;
    have     = 1'b0;
    last_val = '0;
    sat_m    = '0;
    forever begin
      @(posedge clk);
      adv    = bus.running;
      r      = bus.run;
      in_rst = rst;
      #1;
      if (in_rst) begin
        n_adv    = 0;
        have     = 1'b0;
        last_val = '0;
        sat_m    = '0;
        chk("rst_out0", bus.out0, 32'h0);
        continue;
      end
      if (r) sat_m = '0;
      if (adv) begin
        n_adv++;
        if (n_adv >= 3) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
          end else begin
            e = sb.pop_front();
            if (!r && e.valid && e.sat && sat_m != 32'hFFFF_FFFF) sat_m = sat_m + 1;
            last_val = e.val;
            have     = 1'b1;
            chk("out0", bus.out0, e.val);
            $display("txn out0=%h exp=%h valid=%0d sat=%0d sat_count=%0d",
                     bus.out0, e.val, e.valid, e.sat, sat_m);
          end
        end
      end else if (have) begin
        chk("out0_hold", bus.out0, last_val);
      end
      chk("sat_count", bus.sat_count, sat_m);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stimulus
    bit          r;
    bit          rn;
    logic [31:0] f;
    bus.run       = 1'b0;
    bus.running   = 1'b0;
    bus.delay0    = '0;
    bus.frac_bits = '0;
    bus.in0       = '0;
    #1;
    chk("init_out0", bus.out0, 32'h0);
    chk("init_sat", bus.sat_count, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic conversions, specials and saturation by sign
    step(1'b1, 1'b1, 32'h0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 32'h3FC0_0000, 5'd8, 32'd0);
    step(1'b0, 1'b1, 32'hC010_0000, 5'd4, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0001, 5'd4, 32'd0);
    step(1'b0, 1'b1, 32'h7FC0_0000, 5'd4, 32'd0);
    step(1'b0, 1'b1, 32'h8000_0000, 5'd12, 32'd0);
    step(1'b0, 1'b1, 32'h5015_02F9, 5'd0, 32'd0);
    step(1'b0, 1'b1, 32'hCF00_0000, 5'd0, 32'd0);
    step(1'b0, 1'b1, 32'hFF80_0000, 5'd0, 32'd0);
    flush(3);
    chk("directed_sat_two", bus.sat_count, 32'd2);

    // Delay window: only the third consecutive saturating sample is valid
    step(1'b1, 1'b1, 32'h0, 5'd0, 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h7F80_0000, 5'd0, 32'd0);
    flush(3);
    chk("delay_sat_one", bus.sat_count, 32'd1);
    step(1'b1, 1'b1, 32'h3FC0_0000, 5'd8, 32'd0);
    step(1'b0, 1'b1, 32'h3FC0_0000, 5'd8, 32'd0);
    chk("run_clears_sat", bus.sat_count, 32'd0);

    // Stall for four cycles mid-stream, then resume
    step(1'b0, 1'b1, 32'h7F80_0000, 5'd0, 32'd0);
    step(1'b0, 1'b1, 32'h4049_0FDB, 5'd20, 32'd0);
    step(1'b0, 1'b1, 32'hFF80_0000, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h4120_0000, 5'd3, 32'd0);
    step(1'b0, 1'b1, 32'hBF80_0000, 5'd31, 32'd0);
    step(1'b0, 1'b1, 32'h4F00_0000, 5'd0, 32'd0);
    flush(3);
    chk("stall_sat_three", bus.sat_count, 32'd3);

    // Reset mid-stream, then saturating samples without a run are not counted
    step(1'b0, 1'b1, 32'h7F80_0000, 5'd0, 32'd0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h7F80_0000, 5'd0, 32'd0);
    flush(3);
    chk("no_run_no_sat", bus.sat_count, 32'd0);

    // Randomized stream
    step(1'b1, 1'b1, 32'h0, 5'd0, 32'd0);
    for (int i = 0; i < 500; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 9) != 0);
      f  = rand_float();
      step(r, rn, f, 5'($urandom_range(0, 31)), 32'($urandom_range(0, 5)));
    end
    flush(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/my_float_to_fixed.md
MY_FLOAT_TO_FIXED -- requirements
Module: my_float_to_fixed

Interface
REQ-001 Parameter DATA_W, default 32, width of in0/out0; only 32 is supported (IEEE-754 single in, two's-complement fixed out).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 run  input  1  one-cycle start pulse for a new accelerator run.
REQ-005 running  input  1  pipeline advance enable; high for the whole run.
REQ-006 delay0  input  32  config: cycles after run before in0 carries valid data.
REQ-007 frac_bits  input  5  config: number of fractional bits in out0 (0..31).
REQ-008 in0  input  32  float operand {sign, exp[7:0], man[22:0]}.
REQ-009 out0  output  32  signed fixed-point result, Q(31-frac_bits).frac_bits; versat_latency 3.
REQ-010 sat_count  output  32  number of saturated valid results since the last run.

Function
REQ-011 Pipeline SHALL be 3 stages; each stage register loads only when running=1 and holds otherwise.
REQ-012 out0 SHALL equal the conversion of the in0 value presented 3 advancing cycles earlier.
REQ-013 Stage 1 SHALL unpack in0 and compute signed shift = exp - 150 + frac_bits (10-bit signed).
REQ-014 Stage 1 classification: exp==0 (zero/denormal) -> result 0; exp==255 with man!=0 (NaN) -> result 0; exp==255 with man==0 (inf) -> saturate by sign.
REQ-015 Stage 2 SHALL form magnitude {1,man} shifted left by shift if shift>=0, right by -shift otherwise, truncating toward zero; right shift >=24 yields 0.
REQ-016 Stage 2 SHALL flag overflow if the exact magnitude exceeds 2^31-1 (sign=0) or 2^31 (sign=1); left shift >=8 with nonzero mantissa SHALL count as overflow, not wrap.
REQ-017 Stage 3 SHALL register out0 = sign ? -magnitude : magnitude, or 0x7FFFFFFF / 0x80000000 on overflow or inf by sign.
REQ-018 -0.0 SHALL produce 0x00000000.
REQ-019 On run, delay counter SHALL load delay0 and valid tracking SHALL restart; while counter nonzero and not run, it decrements by 1 per cycle.
REQ-020 An input sample SHALL be marked valid when running=1, run=0 and the delay counter is 0; the valid bit travels with the data through all 3 stages.
REQ-021 sat_count SHALL clear to 0 on run and increment by 1 when a valid sample with saturation (REQ-016 overflow or inf) leaves stage 3 while running=1; it SHALL stick at 0xFFFFFFFF.
REQ-022 run and a counted saturation in the same cycle: clear wins.
REQ-023 NaN and zero inputs SHALL NOT increment sat_count.
REQ-024 frac_bits SHALL be sampled per sample at stage 1 and carried with it; changing it mid-run affects only later samples.

Reset
REQ-025 On rst high, out0, sat_count, delay counter, all stage data and valid bits SHALL go to 0 immediately, independent of clk.
REQ-026 rst asserted mid-run SHALL discard in-flight samples; no sat_count increment from them after release.
REQ-027 After rst release, no valid sample until a run pulse has been seen.

Structure
REQ-028 Float field widths (EXP_W=8, MAN_W=23), BIAS=127, saturation constants SHALL live in the shared float package used by the float units.
REQ-029 Stage 1 classification/unpack SHALL be a sub-module float_unpack (combinational, reusable by other float units); the rest stays in my_float_to_fixed.

Verification
REQ-030 in0=0x3FC00000 (1.5), frac_bits=8 -> out0=0x00000180 three cycles later; sat_count=0.
REQ-031 in0=0xC0100000 (-2.25), frac_bits=4 -> out0=0xFFFFFFDC; 0x00000001 (denormal) and 0x7FC00000 (NaN) -> 0x00000000, sat_count unchanged.
REQ-032 in0=0x501502F9 (1e10), frac_bits=0 -> 0x7FFFFFFF, sat_count=1; in0=0xCF000000 (-2^31) -> 0x80000000, sat_count stays 1; 0xFF800000 -> 0x80000000, sat_count=2.
REQ-033 delay0=2, run, then three saturating samples on consecutive cycles -> only the third counted, sat_count=1; second run pulse -> sat_count=0.
REQ-034 Hold running=0 for 4 cycles mid-stream -> out0 frozen, then resumes with correct 3-advance latency; rst pulse mid-stream -> out0=0, sat_count=0 at once.
